// File: rtl/prbs30_pkg.sv
// Shared constants, state encoding and next-bit function for the PRBS30 (x^30+x^6+x^4+x+1) blocks.
// Latency: none; declarations only.
// Backpressure: not applicable.
package prbs30_pkg;

  localparam int PRBS_LEN = 30;

  // Feedback taps, indexed into a shift register whose bit 0 holds the newest bit
  localparam int TAP_A = 29;
  localparam int TAP_B = 5;
  localparam int TAP_C = 3;
  localparam int TAP_D = 0;

  typedef enum logic {
    ACQUIRE = 1'b0,
    CHECK   = 1'b1
  } state_t;

  // Next sequence bit predicted from the last 30 bits
  function automatic logic prbs30_next_bit(input logic [PRBS_LEN-1:0] s);
    return s[TAP_A] ^ s[TAP_B] ^ s[TAP_C] ^ s[TAP_D];
  endfunction

endpackage

// File: rtl/prbs30_step.sv
// One PRBS30 step: predicted next bit and the register value after shifting that bit in.
// Latency: purely combinational.
// Backpressure: none; shared by generator and checker.
module prbs30_step
  import prbs30_pkg::*;
(
  input  logic [PRBS_LEN-1:0] s,
  output logic                p,
  output logic [PRBS_LEN-1:0] s_next
);

  // Predict and advance the sequence by one bit
  always_comb begin
    p      = prbs30_next_bit(s);
    s_next = {s[PRBS_LEN-2:0], p};
  end

endmodule

// File: rtl/prbs30_checker.sv
// PRBS30 stream checker: acquires 30 bits, then self-predicts and counts mismatches; drops lock on error bursts.
// Latency: err_pulse/locked/err_cnt registered, 1 cycle after the bit is sampled.
// Backpressure: none; in_valid qualifies each bit and idle cycles hold state. PRBS30_CHK_BITCNT_EN adds bit_cnt.
module prbs30_checker
  import prbs30_pkg::*;
#(
  parameter int ERR_CNT_W   = 16,
  parameter int LOSS_THRESH = 8,
  parameter int WINDOW      = 64
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic                 in_bit,
  output logic                 locked,
  output logic                 err_pulse,
  output logic [ERR_CNT_W-1:0] err_cnt,
  output logic [31:0]          bit_cnt
);

  localparam int WIN_W  = $clog2(WINDOW);
  localparam int WERR_W = $clog2(LOSS_THRESH + 1);
  localparam int ACQ_W  = $clog2(PRBS_LEN);

  state_t                state_q, state_d;
  logic [PRBS_LEN-1:0]   s_q, s_d, s_acq, s_chk;
  logic [ACQ_W-1:0]      acq_q, acq_d;
  logic [WIN_W-1:0]      win_cnt_q, win_cnt_d;
  logic [WERR_W-1:0]     win_err_q, win_err_d, win_err_inc;
  logic [ERR_CNT_W-1:0]  err_cnt_q, err_cnt_d;
  logic                  pulse_q, pulse_d;
  logic                  pred, mis;

  prbs30_step u_step (
    .s      (s_q),
    .p      (pred),
    .s_next (s_chk)
  );

  // Next state: acquisition loads raw bits; checking free-runs on the prediction so one bad bit stays one error
  always_comb begin
    state_d     = state_q;
    s_d         = s_q;
    acq_d       = acq_q;
    win_cnt_d   = win_cnt_q;
    win_err_d   = win_err_q;
    pulse_d     = 1'b0;
    err_cnt_d   = err_cnt_q;
    s_acq       = {s_q[PRBS_LEN-2:0], in_bit};
    mis         = in_valid && (state_q == CHECK) && (in_bit != pred);
    win_err_inc = win_err_q + WERR_W'(mis);

    if (in_valid) begin
      if (state_q == ACQUIRE) begin
        s_d = s_acq;
        if (acq_q == ACQ_W'(PRBS_LEN - 1)) begin
          acq_d = '0;
          // An all-zero register is the lockup state and would never flag errors
          if (s_acq != '0) begin
            state_d = CHECK;
          end
        end else begin
          acq_d = acq_q + ACQ_W'(1);
        end
      end else begin
        s_d     = s_chk;
        pulse_d = mis;
        if (win_err_inc == WERR_W'(LOSS_THRESH)) begin
          // Loss of lock outranks the window wrap on the same bit
          state_d   = ACQUIRE;
          acq_d     = '0;
          win_cnt_d = '0;
          win_err_d = '0;
        end else if (win_cnt_q == WIN_W'(WINDOW - 1)) begin
          win_cnt_d = '0;
          win_err_d = WERR_W'(mis);
        end else begin
          win_cnt_d = win_cnt_q + WIN_W'(1);
          win_err_d = win_err_inc;
        end
      end
    end

    // clr beats a simultaneous mismatch; counter sticks at all-ones
    if (clr) begin
      err_cnt_d = '0;
    end else if (mis && (err_cnt_q != '1)) begin
      err_cnt_d = err_cnt_q + ERR_CNT_W'(1);
    end
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ACQUIRE;
      s_q       <= '0;
      acq_q     <= '0;
      win_cnt_q <= '0;
      win_err_q <= '0;
      err_cnt_q <= '0;
      pulse_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      acq_q     <= acq_d;
      win_cnt_q <= win_cnt_d;
      win_err_q <= win_err_d;
      err_cnt_q <= err_cnt_d;
      pulse_q   <= pulse_d;
    end
  end

  assign locked    = (state_q == CHECK);
  assign err_pulse = pulse_q;
  assign err_cnt   = err_cnt_q;

`ifdef PRBS30_CHK_BITCNT_EN
  logic [31:0] bit_cnt_q;

  // Count every valid bit checked while locked, wrapping at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt_q <= '0;
    end else if (clr) begin
      bit_cnt_q <= '0;
    end else if (in_valid && (state_q == CHECK)) begin
      bit_cnt_q <= bit_cnt_q + 32'd1;
    end
  end

  assign bit_cnt = bit_cnt_q;
`else
  assign bit_cnt = '0;
`endif

endmodule
